// File: rtl/dx_mdio_pkg.sv
// rtl/dx_mdio_pkg.sv - MDIO frame constants, op codes, bit counts and FSM state type
package dx_mdio_pkg;

   localparam logic [1:0] OP_WR      = 2'b01;
   localparam logic [1:0] OP_RD      = 2'b10;
   localparam logic [1:0] MDIO_ST    = 2'b01;
   localparam logic [1:0] MDIO_TA_WR = 2'b10;

   localparam int unsigned PRE_BITS  = 32;
   localparam int unsigned HDR_BITS  = 14;
   localparam int unsigned TA_BITS   = 2;
   localparam int unsigned DATA_BITS = 16;

`ifdef DX_MDIO_PREAMBLE_EN
   localparam int unsigned FRAME_BITS = PRE_BITS + HDR_BITS + TA_BITS + DATA_BITS;
`else
   localparam int unsigned FRAME_BITS = HDR_BITS + TA_BITS + DATA_BITS;
`endif

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      HDR,
      TA,
      DATA,
      DONE
   } mdio_state_e;

   // Everything after the preamble, MSB first; read frames carry ones where the pin is released
   function automatic logic [31:0] mdio_frame(input logic [1:0]  op,
                                              input logic [4:0]  phy,
                                              input logic [4:0]  ra,
                                              input logic [15:0] wdata);
      if (op == OP_WR) begin
         return {MDIO_ST, op, phy, ra, MDIO_TA_WR, wdata};
      end
      return {MDIO_ST, op, phy, ra, 2'b11, 16'hFFFF};
   endfunction

endpackage

// File: rtl/dx_mdio_clkgen.sv
// rtl/dx_mdio_clkgen.sv - MDC divider with one-cycle rise/fall strobes, held low while disabled
module dx_mdio_clkgen #(
   parameter int CLK_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic mdc_o,
   output logic rise_o,
   output logic fall_o
);

   logic [7:0] cnt_q, cnt_d;
   logic       mdc_q, mdc_d;
   logic       wrap;

   assign wrap   = en_i && (cnt_q == 8'(CLK_DIV - 1));
   assign rise_o = wrap & ~mdc_q;
   assign fall_o = wrap & mdc_q;
   assign mdc_o  = mdc_q;

   // Half-period counter; disabling restarts the phase so every frame begins with a full low half
   always_comb begin
      cnt_d = cnt_q;
      mdc_d = mdc_q;
      if (!en_i) begin
         cnt_d = '0;
         mdc_d = 1'b0;
      end else if (wrap) begin
         cnt_d = '0;
         mdc_d = ~mdc_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Divider state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         mdc_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         mdc_q <= mdc_d;
      end
   end

endmodule

// File: rtl/dx_mdio_master.sv
// rtl/dx_mdio_master.sv - MDIO clause-22 master; DX_MDIO_PREAMBLE_EN enables the 32-bit preamble
module dx_mdio_master
   import dx_mdio_pkg::*;
#(
   parameter int CLK_DIV = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_phy,
   input  logic [4:0]  cmd_reg,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mdc,
   output logic        mdio_dio_i,
   output logic        mdio_dio_t,
   input  logic        mdio_dio_o
);

   mdio_state_e state_q;
   logic [4:0]  bit_cnt_q;
   logic [31:0] shift_q;
   logic        rd_q;
   logic [15:0] rdata_q;
   logic        ta_err_q;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic [15:0] rsp_rdata_q;
   logic        rsp_err_q;
   logic        dio_i_q;
   logic        dio_t_q;

   logic        clk_en;
   logic        mdc_rise;
   logic        mdc_fall;
   logic [31:0] frame_w;

   assign clk_en  = (state_q == PRE) || (state_q == HDR) || (state_q == TA) || (state_q == DATA);
   assign frame_w = mdio_frame(cmd_op, cmd_phy, cmd_reg, cmd_wdata);

   dx_mdio_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk    (clk),
      .rst    (rst),
      .en_i   (clk_en),
      .mdc_o  (mdc),
      .rise_o (mdc_rise),
      .fall_o (mdc_fall)
   );

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign mdio_dio_i = dio_i_q;
   assign mdio_dio_t = dio_t_q;

   // Frame sequencer: next bit goes out on each MDC fall, read bits are taken on each MDC rise
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rd_q        <= 1'b0;
         rdata_q     <= '0;
         ta_err_q    <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         dio_i_q     <= 1'b1;
         dio_t_q     <= 1'b1;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  rd_q        <= (cmd_op == OP_RD);
                  bit_cnt_q   <= '0;
                  rdata_q     <= '0;
                  ta_err_q    <= 1'b0;
                  if ((cmd_op == OP_WR) || (cmd_op == OP_RD)) begin
                     shift_q <= frame_w;
                     dio_t_q <= 1'b0;
`ifdef DX_MDIO_PREAMBLE_EN
                     state_q <= PRE;
                     dio_i_q <= 1'b1;
`else
                     state_q <= HDR;
                     dio_i_q <= frame_w[31];
`endif
                  end else begin
                     // Unsupported op: complete at once with an error and leave the bus alone
                     state_q     <= DONE;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end
               end
            end
            PRE: begin
               if (mdc_fall) begin
                  if (bit_cnt_q == 5'(PRE_BITS - 1)) begin
                     state_q   <= HDR;
                     bit_cnt_q <= '0;
                     dio_i_q   <= shift_q[31];
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end
            HDR: begin
               if (mdc_fall) begin
                  shift_q <= {shift_q[30:0], 1'b0};
                  dio_i_q <= shift_q[30];
                  if (bit_cnt_q == 5'(HDR_BITS - 1)) begin
                     state_q   <= TA;
                     bit_cnt_q <= '0;
                     if (rd_q) begin
                        dio_t_q <= 1'b1;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end
            TA: begin
               // Only the second turnaround bit is driven by a present PHY (low)
               if (mdc_rise && (bit_cnt_q == 5'(TA_BITS - 1))) begin
                  ta_err_q <= mdio_dio_o;
               end
               if (mdc_fall) begin
                  shift_q <= {shift_q[30:0], 1'b0};
                  dio_i_q <= shift_q[30];
                  if (bit_cnt_q == 5'(TA_BITS - 1)) begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end
            DATA: begin
               if (mdc_rise) begin
                  rdata_q <= {rdata_q[14:0], mdio_dio_o};
               end
               if (mdc_fall) begin
                  if (bit_cnt_q == 5'(DATA_BITS - 1)) begin
                     state_q     <= DONE;
                     bit_cnt_q   <= '0;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rd_q ? rdata_q : 16'h0000;
                     rsp_err_q   <= rd_q & ta_err_q;
                     dio_i_q     <= 1'b1;
                     dio_t_q     <= 1'b1;
                  end else begin
                     shift_q   <= {shift_q[30:0], 1'b0};
                     dio_i_q   <= shift_q[30];
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end
            DONE: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dx_mdio_master.sv
// tb/tb_dx_mdio_master.sv - directed self-checking bench for dx_mdio_master at CLK_DIV=4
module tb_dx_mdio_master;

`ifdef DX_MDIO_PREAMBLE_EN
   localparam int FB  = 64;
   localparam int LAT = 513;
`else
   localparam int FB  = 32;
   localparam int LAT = 257;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_phy = 5'h00;
   logic [4:0]  cmd_reg = 5'h00;
   logic [15:0] cmd_wdata = 16'h0000;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        mdc;
   logic        mdio_dio_i;
   logic        mdio_dio_t;
   logic        mdio_dio_o;

   int total = 0;
   int bad   = 0;

   // PHY model and line monitor state
   logic [63:0] phy_bits = '1;
   logic [63:0] cap_i = '0;
   logic [63:0] cap_t = '0;
   int          bit_idx = 0;
   int          rise_cnt = 0;
   logic        prev_mdc = 1'b0;
   logic        phy_bit;

   always #5 clk = ~clk;

   dx_mdio_master #(
      .CLK_DIV (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_phy    (cmd_phy),
      .cmd_reg    (cmd_reg),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mdc        (mdc),
      .mdio_dio_i (mdio_dio_i),
      .mdio_dio_t (mdio_dio_t),
      .mdio_dio_o (mdio_dio_o)
   );

   always_comb begin
      phy_bit = 1'b1;
      if (bit_idx < FB) phy_bit = phy_bits[FB - 1 - bit_idx];
   end

   assign mdio_dio_o = mdio_dio_t ? phy_bit : mdio_dio_i;

   always @(negedge clk) begin
      if (cmd_valid && cmd_ready && !rst) begin
         bit_idx  <= 0;
         rise_cnt <= 0;
         cap_i    <= '0;
         cap_t    <= '0;
      end else begin
         if (prev_mdc && !mdc) bit_idx <= bit_idx + 1;
         if (!prev_mdc && mdc) begin
            rise_cnt <= rise_cnt + 1;
            if (bit_idx < FB) begin
               cap_i[FB - 1 - bit_idx] <= mdio_dio_i;
               cap_t[FB - 1 - bit_idx] <= mdio_dio_t;
            end
         end
      end
      prev_mdc <= mdc;
   end

   task automatic do_cmd(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [15:0] wd, output int lat);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_phy   = phy;
      cmd_reg   = ra;
      cmd_wdata = wd;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 2000; n++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (rsp_rdata !== 16'h0000 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%h/%b exp=0000/0", rsp_rdata, rsp_err); end
      total++; if (mdc !== 1'b0 || mdio_dio_t !== 1'b1 || mdio_dio_i !== 1'b1) begin bad++; $display("FAIL reset_pins mdc=%b t=%b i=%b exp=0/1/1", mdc, mdio_dio_t, mdio_dio_i); end
   endtask

   task automatic test_write();
      int lat;
      logic [63:0] exp_i;
      phy_bits = '1;
      exp_i = (FB == 64) ? 64'hFFFF_FFFF_5082_1140 : 64'h0000_0000_5082_1140;
      do_cmd(2'b01, 5'h01, 5'h00, 16'h1140, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL write_latency got=%0d exp=%0d", lat, LAT); end
      total++; if (rsp_err !== 1'b0 || rsp_rdata !== 16'h0000) begin bad++; $display("FAIL write_rsp got=%h/%b exp=0000/0", rsp_rdata, rsp_err); end
      total++; if (cap_i !== exp_i) begin bad++; $display("FAIL write_stream got=%h exp=%h", cap_i, exp_i); end
      total++; if (cap_t !== 64'h0) begin bad++; $display("FAIL write_dio_t got=%h exp=0", cap_t); end
      total++; if (rise_cnt !== FB) begin bad++; $display("FAIL write_mdc_rises got=%0d exp=%0d", rise_cnt, FB); end
      @(negedge clk);
      total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL write_return_idle ready=%b valid=%b exp=1/0", cmd_ready, rsp_valid); end
      total++; if (mdc !== 1'b0) begin bad++; $display("FAIL write_mdc_idle got=%b exp=0", mdc); end
   endtask

   task automatic test_read();
      int lat;
      phy_bits = 64'hFFFF_FFFF_FFFE_0141;
      do_cmd(2'b10, 5'h03, 5'h02, 16'h0000, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL read_latency got=%0d exp=%0d", lat, LAT); end
      total++; if (rsp_rdata !== 16'h0141) begin bad++; $display("FAIL read_rdata got=%h exp=0141", rsp_rdata); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL read_err got=%b exp=0", rsp_err); end
      total++; if (cap_i[31:18] !== 14'b01100001100010) begin bad++; $display("FAIL read_header got=%b exp=01100001100010", cap_i[31:18]); end
      total++; if (cap_t !== 64'h0000_0000_0003_FFFF) begin bad++; $display("FAIL read_dio_t got=%h exp=000000000003ffff", cap_t); end
      repeat (10) @(negedge clk);
      total++; if (rsp_rdata !== 16'h0141 || rsp_err !== 1'b0) begin bad++; $display("FAIL read_hold got=%h/%b exp=0141/0", rsp_rdata, rsp_err); end
   endtask

   task automatic test_read_nophy();
      int lat;
      phy_bits = '1;
      do_cmd(2'b10, 5'h1F, 5'h01, 16'h0000, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL nophy_latency got=%0d exp=%0d", lat, LAT); end
      total++; if (rsp_rdata !== 16'hFFFF) begin bad++; $display("FAIL nophy_rdata got=%h exp=ffff", rsp_rdata); end
      total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL nophy_err got=%b exp=1", rsp_err); end
   endtask

   task automatic test_bad_op();
      int lat;
      logic [1:0] ops [2];
      ops[0] = 2'b11;
      ops[1] = 2'b00;
      for (int k = 0; k < 2; k++) begin
         do_cmd(ops[k], 5'h01, 5'h01, 16'hFFFF, lat);
         total++; if (lat !== 1) begin bad++; $display("FAIL badop_latency op=%b got=%0d exp=1", ops[k], lat); end
         total++; if (rsp_err !== 1'b1 || rsp_rdata !== 16'h0000) begin bad++; $display("FAIL badop_rsp op=%b got=%h/%b exp=0000/1", ops[k], rsp_rdata, rsp_err); end
         @(negedge clk);
         total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL badop_idle op=%b ready=%b valid=%b exp=1/0", ops[k], cmd_ready, rsp_valid); end
         repeat (20) @(negedge clk);
         total++; if (rise_cnt !== 0 || mdio_dio_t !== 1'b1) begin bad++; $display("FAIL badop_quiet op=%b rises=%0d t=%b exp=0/1", ops[k], rise_cnt, mdio_dio_t); end
      end
   endtask

   task automatic test_rst_abort();
      int lat;
      int abort_bit;
      bit seen;
      bit got_rsp;
      bit mdc_seen;
      logic [63:0] exp_i;
      phy_bits  = '1;
      abort_bit = (FB == 64) ? 40 : 20;
      seen      = 1'b0;
      got_rsp   = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_phy   = 5'h01;
      cmd_reg   = 5'h04;
      cmd_wdata = 16'hA5A5;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (rsp_valid) got_rsp = 1'b1;
         if (bit_idx == abort_bit) begin
            seen = 1'b1;
            break;
         end
      end
      total++; if (!seen || got_rsp) begin bad++; $display("FAIL abort_reach_bit seen=%b rsp=%b exp=1/0", seen, got_rsp); end
      @(posedge clk); #1;
      rst       = 1'b1;
      cmd_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++; if (mdc !== 1'b0 || mdio_dio_t !== 1'b1) begin bad++; $display("FAIL abort_pins mdc=%b t=%b exp=0/1", mdc, mdio_dio_t); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_rsp_valid got=%b exp=0", rsp_valid); end
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      got_rsp   = 1'b0;
      mdc_seen  = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (rsp_valid) got_rsp = 1'b1;
         if (mdc) mdc_seen = 1'b1;
      end
      total++; if (got_rsp || mdc_seen) begin bad++; $display("FAIL abort_quiet rsp=%b mdc=%b exp=0/0", got_rsp, mdc_seen); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
      exp_i = (FB == 64) ? 64'hFFFF_FFFF_510E_BEEF : 64'h0000_0000_510E_BEEF;
      do_cmd(2'b01, 5'h02, 5'h03, 16'hBEEF, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL after_abort_latency got=%0d exp=%0d", lat, LAT); end
      total++; if (cap_i !== exp_i) begin bad++; $display("FAIL after_abort_stream got=%h exp=%h", cap_i, exp_i); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL after_abort_err got=%b exp=0", rsp_err); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_nophy();
      test_bad_op();
      test_rst_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
